// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver, 16x oversampled with 3-sample majority vote, feeding a small byte FIFO.
// Ports: clk system clock; rst async active-low reset; rx serial line (idle high, async);
//   rd pop strobe; clr_err clears sticky flags; DO FIFO head byte (0 when empty);
//   STATUS {4'b0, busy, ovr, ferr, ready}; ready FIFO not empty; ferr sticky framing error;
//   ovr sticky overrun; busy frame in progress.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int DIV        = (CLK_HZ + BAUD * 8) / (BAUD * 16),
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] DO,
  output logic [7:0] STATUS,
  output logic       ready,
  output logic       ferr,
  output logic       ovr,
  output logic       busy
);
  localparam int CW = $clog2(DIV);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BRK = 3'd4;
  logic [1:0] sync_q;
  logic prev_q;
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] s_q, s_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] v_q, v_d;
  logic [7:0] sh_q, sh_d;
  logic [DEPTH_LOG2:0] wp_q, wp_d, rp_q, rp_d;
  logic ferr_q, ferr_d, ovr_q, ovr_d;
  logic [7:0] mem [1 << DEPTH_LOG2];
  logic rxs, tick, maj, s9, s15, push, ferr_set, empty, full, pop, wr, ovr_set;
  assign rxs = sync_q[1];
  assign tick = (state_q != IDLE) && (cnt_q == CW'(DIV - 1));
  assign maj = (v_q[0] & v_q[1]) | (v_q[0] & rxs) | (v_q[1] & rxs);
  assign s9 = tick && (s_q == 4'd9);
  assign s15 = tick && (s_q == 4'd15);
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    s_d = (state_q == IDLE) ? 4'd0 : s_q + {3'b000, tick};
    v_d = (tick && s_q == 4'd7) ? {v_q[1], rxs} : (tick && s_q == 4'd8) ? {rxs, v_q[0]} : v_q;
    bit_d = bit_q;
    sh_d = sh_q;
    push = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: if (prev_q && !rxs) state_d = START;
      START: begin
        if (s9 && maj) state_d = IDLE;
        else if (s15) begin
          state_d = DATA;
          bit_d = 3'd0;
        end
      end
      DATA: begin
        if (s9) sh_d = {maj, sh_q[7:1]};
        if (s15) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (s9 && maj) begin
          push = 1'b1;
          state_d = IDLE;
        end else if (s9) begin
          ferr_set = 1'b1;
          state_d = BRK;
        end
      end
      BRK: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wp_q == rp_q);
  assign full = (wp_q == (rp_q ^ {1'b1, {DEPTH_LOG2{1'b0}}}));
  assign pop = rd && !empty;
  assign wr = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign wp_d = wp_q + (DEPTH_LOG2 + 1)'(wr);
  assign rp_d = rp_q + (DEPTH_LOG2 + 1)'(pop);
  assign ferr_d = ferr_set | (ferr_q & ~clr_err);
  assign ovr_d = ovr_set | (ovr_q & ~clr_err);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      s_q <= 4'd0;
      bit_q <= 3'd0;
      v_q <= 2'b00;
      sh_q <= 8'h00;
      wp_q <= '0;
      rp_q <= '0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      prev_q <= rxs;
      state_q <= state_d;
      cnt_q <= cnt_d;
      s_q <= s_d;
      bit_q <= bit_d;
      v_q <= v_d;
      sh_q <= sh_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp_q[DEPTH_LOG2-1:0]] <= sh_q;
  end
  // Head byte is forced to zero while empty so DO is defined out of reset.
  assign ready = !empty;
  assign DO = ready ? mem[rp_q[DEPTH_LOG2-1:0]] : 8'h00;
  assign ferr = ferr_q;
  assign ovr = ovr_q;
  assign busy = (state_q != IDLE);
  assign STATUS = {4'b0000, busy, ovr, ferr, ready};
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver (8N1) for the UART_RX pin; the CPU reads it at I/O port 0xE8 (data) and port 0xE9 (status).
- Oversamples the line at 16x baud and majority-votes each bit.
- Queues received bytes in a small FIFO so the 8080 polling loop does not lose characters.
- Sits beside the I/O read mux in the top level; the transmitter for the same ports is a separate block.

Parameters:
- CLK_HZ, 27000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- DIV, (CLK_HZ+BAUD*8)/(BAUD*16): clocks per oversample tick, rounded; must be >= 2.
- DEPTH_LOG2, 2: FIFO depth is 2^DEPTH_LOG2 entries (default 4).

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: asynchronous, active-low reset.
- rx, input, 1: serial line, idle high, asynchronous to clk.
- rd, input, 1: pop strobe, active-high, one clk per byte; the top level derives it from a port-0xE8 read.
- clr_err, input, 1: one-clk pulse that clears the sticky error flags.
- DO, output, 8: FIFO head byte; valid when ready=1.
- STATUS, output, 8: {4'b0000, busy, ovr, ferr, ready}.
- ready, output, 1: FIFO not empty.
- ferr, output, 1: sticky framing error.
- ovr, output, 1: sticky overrun.
- busy, output, 1: frame reception in progress.

Behaviour:
- Reset (rst=0, async):
  - Synchronizer flops = 1, state IDLE, all counters 0, FIFO empty.
  - DO=0x00, ready=0, ferr=0, ovr=0, busy=0, STATUS=0x00.
  - Reset mid-frame abandons the frame; nothing is pushed.
- Input synchronizer: 2 flops on rx; all logic uses the synchronized value (rxs). Line-to-rxs latency is 2 clk.
- Tick generator:
  - Counter 0..DIV-1; tick is asserted for 1 clk when it wraps.
  - The counter is forced to 0 in IDLE, so bit timing is anchored to the start edge.
- Sampling: within each bit, sample index s counts ticks 0..15. The bit value is the majority of rxs at s=7,8,9 and is decided at s=9.
- FSM:
  - IDLE: busy=0. A falling edge on rxs (previous 1, now 0) -> START, s=0, busy=1.
  - START: at s=9, majority=1 -> IDLE (glitch rejected, no flag set). Majority=0 -> continue; at s=15 -> DATA, bit index 0.
  - DATA: 8 bits, LSB first, each 16 ticks; the bit is shifted into the shift register at s=9. After bit 7, at s=15 -> STOP.
  - STOP, at s=9, majority=1: request a FIFO push, then -> IDLE immediately. This leaves a half-bit margin for a back-to-back start edge.
  - STOP, at s=9, majority=0: set ferr, discard the byte, -> BRK.
  - BRK: busy=1; wait until rxs=1, then -> IDLE. A break produces exactly one ferr and no data.
- FIFO:
  - Circular buffer, 2^DEPTH_LOG2 entries; pointers are DEPTH_LOG2+1 bits wide for full/empty detection.
  - DO is the head entry, combinational from storage and pointer; ready=!empty.
  - A push is written on the stop-sample clk, so ready/DO are valid on the following clk.
  - rd while empty: ignored, no state change.
  - Push while full and no pop: byte dropped, ovr set, contents unchanged.
  - Push and pop in the same clk while full: both take effect; count unchanged; ovr not set.
  - Push and pop in the same clk while empty: push only; ready=1 on the next clk.
  - Pointers wrap modulo the depth.
- Error flags:
  - ferr and ovr stay set until a clr_err pulse.
  - If clr_err and a new set event occur in the same clk, the flag ends set (set wins).
  - clr_err does not affect FIFO contents.

Test Plan:
- Bench configuration: CLK_HZ=1843200, BAUD=28800, so DIV=4 and one bit = 64 clk.
1. Reset sequence: hold rst=0 with rx toggling -> STATUS=0x00 and DO=0x00 throughout. After release with idle line -> nothing changes.
2. Send 0xA5 (8N1) -> busy rises 3 clk after the start edge. ready=1 and DO=0xA5 appear 1 clk after the stop sample (about 9.6 bits after the start edge). rd pulse -> ready=0, STATUS=0x00.
3. Start glitch: rx low for 20 clk, then high -> no push, busy returns to 0, ferr=0. A valid 0x3C sent afterwards is received correctly.
4. Framing: send 0x55 with stop bit=0, then hold low for 2 frames (break) -> ferr=1, FIFO empty, a single ferr event. After line high, 0x81 is received OK. clr_err -> ferr=0.
5. Overrun: send 0x01..0x05 back-to-back with no rd -> after byte 5, ovr=1. Reads return 0x01,0x02,0x03,0x04, then ready=0.
6. Simultaneous push+pop with FIFO full: assert rd on the stop-sample clk of byte 5 -> ovr stays 0. Reads return 0x02,0x03,0x04,0x05.
